// File: rtl/ay_bus_pkg.sv
// Shared definitions for the AY sound-chip bus master.
// Op codes, bus control codes and configuration register layout.
package ay_bus_pkg;

   localparam logic [1:0] OP_LATCH = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_CONF  = 2'd3;

   // {bdir, bc2, bc1}
   localparam logic [2:0] BUS_INACTIVE = 3'b010;
   localparam logic [2:0] BUS_LATCH    = 3'b111;
   localparam logic [2:0] BUS_WRITE    = 3'b110;
   localparam logic [2:0] BUS_READ     = 3'b011;

   localparam int CONF_CHIP_SEL   = 0;
   localparam int CONF_STATUS_SEL = 1;
   localparam int CONF_FM_DIS     = 2;
   localparam int CONF_SAA_DIS    = 3;

   localparam logic [3:0] CONF_RESET = 4'b1110;

   typedef struct packed {
      logic [1:0] op;
      logic       chip;
      logic [7:0] data;
   } ay_req_t;

   // Active bus code driven while the strobe phase is open.
   function automatic logic [2:0] strobe_code(input logic [1:0] op);
      logic [2:0] code;
      code = BUS_INACTIVE;
      case (op)
         OP_LATCH: code = BUS_LATCH;
         OP_WRITE: code = BUS_WRITE;
         OP_READ:  code = BUS_READ;
         OP_CONF:  code = BUS_LATCH;
         default:  code = BUS_INACTIVE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// Loadable 4-bit down-counter timing each bus phase.
// done is high while the count has reached zero.
module ay_phase_timer
   import ay_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] value,
   output logic       done
);

   logic [3:0] count;

   // Load on phase entry, then count down to zero and stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= value;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/ay_bus_master.sv
// Host-to-AY bus master: SETUP / STROBE / HOLD cycle sequencer.
// Optional TFM_CONF_SHADOW_EN adds the conf_shadow register output.
module ay_bus_master
   import ay_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 8,
   parameter int HOLD_CYC   = 2
) (
   input  logic       fclk,
   input  logic       ayres,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic       req_chip,
   input  logic [7:0] req_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       aybdir,
   output logic       aybc2,
   output logic       aybc1,
   output logic       aya8,
   output logic       aya9_n,
   output logic [7:0] ayd_o,
   output logic       ayd_oe,
   input  logic [7:0] ayd_i,
`ifdef TFM_CONF_SHADOW_EN
   output logic [3:0] conf_shadow,
`endif
   output logic       busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   // Counter is loaded with N-1 so each phase lasts exactly N cycles.
   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       tmr_load;
   logic [3:0] tmr_value;
   logic       tmr_done;
   ay_req_t    req_q;
   logic       last_strobe;
   logic [2:0] bus_code;

   ay_phase_timer u_timer (
      .clk   (fclk),
      .rst   (ayres),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done)
   );

   assign req_ready   = req_valid && (state_q == ST_IDLE) && !ayres;
   assign busy        = (state_q != ST_IDLE);
   assign last_strobe = (state_q == ST_STROBE) && tmr_done;

   // Phase sequencing and timer loads on each phase entry.
   always_comb begin
      state_d   = state_q;
      tmr_load  = 1'b0;
      tmr_value = 4'd0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_value = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tmr_done) begin
               state_d   = ST_STROBE;
               tmr_load  = 1'b1;
               tmr_value = STROBE_LD;
            end
         end
         ST_STROBE: begin
            if (tmr_done) begin
               state_d   = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_value = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset aborts any cycle in flight.
   always_ff @(posedge fclk) begin
      if (ayres) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request on acceptance and hold it for the whole cycle.
   always_ff @(posedge fclk) begin
      if (ayres) begin
         req_q <= '0;
      end else if (req_ready) begin
         req_q.op   <= req_op;
         req_q.chip <= req_chip;
`ifdef TFM_CONF_SHADOW_EN
         if (req_op == OP_CONF) begin
            req_q.data <= {4'hF, req_data[3:0]};
         end else begin
            req_q.data <= req_data;
         end
`else
         req_q.data <= req_data;
`endif
      end
   end

   // Sample read data on the last strobe cycle; pulse on first HOLD cycle.
   always_ff @(posedge fclk) begin
      if (ayres) begin
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         rd_valid <= last_strobe && (req_q.op == OP_READ);
         if (last_strobe && (req_q.op == OP_READ)) begin
            rd_data <= ayd_i;
         end
      end
   end

`ifdef TFM_CONF_SHADOW_EN
   // Shadow of the configuration nibble, updated as op 3 enters HOLD.
   always_ff @(posedge fclk) begin
      if (ayres) begin
         conf_shadow <= CONF_RESET;
      end else if (last_strobe && (req_q.op == OP_CONF)) begin
         conf_shadow <= req_q.data[3:0];
      end
   end
`endif

   // Bus outputs decoded from the current phase and captured request.
   always_comb begin
      bus_code = BUS_INACTIVE;
      ayd_oe   = 1'b0;
      if (state_q == ST_STROBE) begin
         bus_code = strobe_code(req_q.op);
      end
      if ((state_q == ST_SETUP) || (state_q == ST_STROBE)) begin
         ayd_oe = (req_q.op != OP_READ);
      end
   end

   assign {aybdir, aybc2, aybc1} = bus_code;
   assign aya8   = busy && req_q.chip;
   assign aya9_n = !(busy && req_q.chip);
   assign ayd_o  = req_q.data;

endmodule

// File: tb/tb_ay_bus_master.sv
// Self-checking bench for ay_bus_master against a cycle-offset model.
// Build with TFM_CONF_SHADOW_EN to also check conf_shadow.
module tb_ay_bus_master;

   localparam int S = 2;
   localparam int T = 8;
   localparam int H = 2;
   localparam int PERIOD = 1 + S + T + H;

   logic       fclk = 1'b0;
   logic       ayres;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic       req_chip;
   logic [7:0] req_data;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       aybdir, aybc2, aybc1;
   logic       aya8, aya9_n;
   logic [7:0] ayd_o;
   logic       ayd_oe;
   logic [7:0] ayd_i;
   logic       busy;
`ifdef TFM_CONF_SHADOW_EN
   logic [3:0] conf_shadow;
`endif

   ay_bus_master #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .HOLD_CYC   (H)
   ) dut (
      .fclk      (fclk),
      .ayres     (ayres),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_chip  (req_chip),
      .req_data  (req_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .aybdir    (aybdir),
      .aybc2     (aybc2),
      .aybc1     (aybc1),
      .aya8      (aya8),
      .aya9_n    (aya9_n),
      .ayd_o     (ayd_o),
      .ayd_oe    (ayd_oe),
      .ayd_i     (ayd_i),
`ifdef TFM_CONF_SHADOW_EN
      .conf_shadow (conf_shadow),
`endif
      .busy      (busy)
   );

   always #5 fclk = ~fclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: busy flag plus cycle offset since acceptance.
   bit         m_busy = 0;
   int         m_k = 0;
   logic [1:0] m_op;
   logic       m_chip;
   logic [7:0] m_data;
   bit         m_rdv = 0;
   logic [7:0] m_rdd;
   logic [3:0] m_shadow = 4'b1110;

   int  cyc = 0;
   bit  track = 0;
   int  last_acc = -1;
   int  strobe_cnt = 0;
   int  rd_cnt = 0;
   int  n_acc = 0;
   logic [7:0] din_hit = 8'h00;
   logic [7:0] din_miss = 8'h00;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] op,
                       input logic ch, input logic [7:0] d,
                       input logic r);
      bit         in_setup, in_strobe, exp_rdy, nrdv;
      logic [2:0] exp_code;
      logic [7:0] exp_do;
      @(negedge fclk);
      req_valid = v;
      req_op    = op;
      req_chip  = ch;
      req_data  = d;
      ayres     = r;
      ayd_i = (m_busy && m_k == S + T) ? din_hit : din_miss;
      #1;
      in_setup  = m_busy && m_k <= S;
      in_strobe = m_busy && m_k > S && m_k <= S + T;
      exp_rdy   = v && !m_busy && !r;
      exp_code  = 3'b010;
      if (in_strobe) begin
         if (m_op == 2'd2) exp_code = 3'b011;
         else if (m_op == 2'd1) exp_code = 3'b110;
         else exp_code = 3'b111;
      end
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, m_busy);
      check("bus_code", {aybdir, aybc2, aybc1}, exp_code);
      check("aya8", aya8, m_busy && m_chip);
      check("aya9_n", aya9_n, !(m_busy && m_chip));
      check("ayd_oe", ayd_oe, (in_setup || in_strobe) && m_op != 2'd2);
      if (m_busy) begin
         exp_do = m_data;
`ifdef TFM_CONF_SHADOW_EN
         if (m_op == 2'd3) exp_do = {4'hF, m_data[3:0]};
`endif
         check("ayd_o", ayd_o, exp_do);
      end
      check("rd_valid", rd_valid, m_rdv);
      if (m_rdv) check("rd_data", rd_data, m_rdd);
`ifdef TFM_CONF_SHADOW_EN
      check("conf_shadow", conf_shadow, m_shadow);
`endif
      if (rd_valid) rd_cnt++;
      if ({aybdir, aybc2, aybc1} == 3'b110) strobe_cnt++;
      if (req_ready) begin
         if (track && last_acc >= 0)
            check("acc_gap", cyc - last_acc, PERIOD);
         last_acc = cyc;
         n_acc++;
      end
      nrdv = 0;
      if (r) begin
         m_busy = 0;
         m_shadow = 4'b1110;
      end else begin
         if (in_strobe && m_k == S + T) begin
            if (m_op == 2'd2) begin
               nrdv = 1;
               m_rdd = ayd_i;
            end
            if (m_op == 2'd3) m_shadow = m_data[3:0];
         end
         if (exp_rdy) begin
            m_busy = 1;
            m_k    = 1;
            m_op   = op;
            m_chip = ch;
            m_data = d;
         end else if (m_busy) begin
            m_k++;
            if (m_k > S + T + H) m_busy = 0;
         end
      end
      m_rdv = nrdv;
      cyc++;
   endtask

   // Hold req_valid until the request is accepted (bounded).
   task automatic issue(input logic [1:0] op, input logic ch,
                        input logic [7:0] d);
      int guard;
      bit acc;
      guard = 0;
      acc = 0;
      while (!acc && guard < 4 * PERIOD) begin
         acc = !m_busy;
         step(1'b1, op, ch, d, 1'b0);
         guard++;
      end
      if (!acc) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((m_busy || m_rdv) && guard < 4 * PERIOD) begin
         step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
         guard++;
      end
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      ayres = 1'b1;
      req_valid = 1'b0;
      req_op = 2'd0;
      req_chip = 1'b0;
      req_data = 8'h00;
      ayd_i = 8'h00;
      repeat (3) @(posedge fclk);

      // Reset state, then latch 07 followed back-to-back by write 3F.
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
      track = 1;
      last_acc = -1;
      issue(2'd0, 1'b1, 8'h07);
      issue(2'd1, 1'b1, 8'h3F);
      drain();
      track = 0;

      // Read with the bus value present only on the last strobe cycle.
      din_hit = 8'hA5;
      din_miss = 8'h00;
      rd_cnt = 0;
      issue(2'd2, 1'b1, 8'h00);
      drain();
      check("rd_pulses", rd_cnt, 1);

      // Three writes with req_valid held continuously.
      strobe_cnt = 0;
      n_acc = 0;
      track = 1;
      last_acc = -1;
      issue(2'd1, 1'b1, 8'h11);
      issue(2'd1, 1'b1, 8'h22);
      issue(2'd1, 1'b1, 8'h33);
      drain();
      track = 0;
      check("write_strobes", strobe_cnt, 3 * T);
      check("write_accepts", n_acc, 3);

      // Configuration select with data 05.
      issue(2'd3, 1'b1, 8'h05);
      drain();

      // Reset in the middle of a write strobe.
      issue(2'd1, 1'b1, 8'h5A);
      while (m_busy && m_k < S + 3) step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 2'd1, 1'b1, 8'h00, 1'b1);
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);

      // Reset on the last strobe cycle of a read: no rd_valid expected.
      rd_cnt = 0;
      issue(2'd2, 1'b0, 8'h00);
      while (m_busy && m_k < S + T) step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
      drain();
      check("rd_after_reset", rd_cnt, 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         din_hit  = 8'($urandom);
         din_miss = 8'($urandom);
         step(($urandom % 3) != 0, 2'($urandom), 1'($urandom),
              8'($urandom), ($urandom % 60) == 0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
